// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11/DHT22 multi-channel reader.
// Contents: FSM state encoding, err_code values, frame width, mode values,
// fixed protocol timings and a frame checksum helper.
package dht_pkg;

  localparam int unsigned DHT_FRAME_W = 40;
  localparam int unsigned CNT_W       = 15;  // phase counter width (saturating)

  // Fixed protocol windows in microseconds
  localparam int unsigned T_REL_US       = 20;  // host release before sampling response
  localparam int unsigned T_RESP_WAIT_US = 40;  // window for the sensor to pull low

  localparam logic MODE_DHT11 = 1'b0;
  localparam logic MODE_DHT22 = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StWake,
    StRel,
    StWaitLow,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StCheck,
    StRecover,
    StFin
  } dht_state_e;

  localparam logic [2:0] ErrOk       = 3'd0;
  localparam logic [2:0] ErrNoResp   = 3'd1;
  localparam logic [2:0] ErrRespLow  = 3'd2;
  localparam logic [2:0] ErrRespHigh = 3'd3;
  localparam logic [2:0] ErrBitLow   = 3'd4;
  localparam logic [2:0] ErrBitHigh  = 3'd5;
  localparam logic [2:0] ErrChecksum = 3'd6;

  // Low byte must equal the mod-256 sum of the four data bytes
  function automatic logic frame_sum_ok(input logic [DHT_FRAME_W-1:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return s == f[7:0];
  endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Microsecond strobe generator.
// Ports: clk, rst_n (async, active-low) -> tick, a one-cycle pulse every
// CLK_HZ/1e6 clocks (every clock when CLK_HZ is 1 MHz).
module dht_us_tick #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned Div  = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/dht_multi_reader.sv
// Multi-channel DHT11/DHT22 single-wire sensor controller.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           request, sampled only while idle
//   ch_sel, mode    channel and sensor type (0=DHT11, 1=DHT22), latched with start
//   dht_data        open-drain sensor pins, driven 0 or Z only
//   busy            high from the cycle after start until done
//   done            one-cycle result strobe
//   err_code        0 ok, 1 no response, 2..5 phase timeouts, 6 checksum mismatch
//   ch_out          channel of the result
//   frame           raw 40-bit frame {hum_hi, hum_lo, tmp_hi, tmp_lo, sum}
module dht_multi_reader
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned T_WAKE11_US = 19000,
  parameter int unsigned T_WAKE22_US = 1100,
  parameter int unsigned T_TMO_US    = 100,
  parameter int unsigned T_BIT1_US   = 50,
  parameter int unsigned T_REC_US    = 100,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic                   mode,
  inout  wire  [NUM_CH-1:0]      dht_data,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             err_code,
  output logic [CH_W-1:0]        ch_out,
  output logic [DHT_FRAME_W-1:0] frame
);

  // Limits are "last count before expiry": a phase ends on the tick seen at limit-1
  localparam logic [CNT_W-1:0] Wake11Lim = CNT_W'(T_WAKE11_US - 1);
  localparam logic [CNT_W-1:0] Wake22Lim = CNT_W'(T_WAKE22_US - 1);
  localparam logic [CNT_W-1:0] RelLim    = CNT_W'(T_REL_US - 1);
  localparam logic [CNT_W-1:0] WaitLim   = CNT_W'(T_RESP_WAIT_US - 1);
  localparam logic [CNT_W-1:0] TmoLim    = CNT_W'(T_TMO_US - 1);
  localparam logic [CNT_W-1:0] RecLim    = CNT_W'(T_REC_US - 1);
  localparam logic [CNT_W-1:0] Bit1Thr   = CNT_W'(T_BIT1_US);
  localparam logic [5:0]       LastBit   = 6'(DHT_FRAME_W - 1);

  logic tick;

  dht_us_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_us_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  dht_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [5:0]             bit_cnt_q;
  logic [DHT_FRAME_W-1:0] sh_q;
  logic [CH_W-1:0]        ch_q;
  logic                   mode_q;
  logic [2:0]             err_q;
  logic                   drv_q;
  logic [NUM_CH-1:0]      sync1_q, sync2_q, drv_low;
  logic [CNT_W-1:0]       wake_lim;
  logic                   pin_lvl;
  logic                   ch_ok;
  logic                   tmo;

  // Open-drain pins: only the latched channel is ever pulled low
  for (genvar i = 0; i < NUM_CH; i++) begin : g_pin
    assign drv_low[i]  = drv_q && (ch_q == CH_W'(i));
    assign dht_data[i] = drv_low[i] ? 1'b0 : 1'bz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= dht_data;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    ch_ok = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) ch_ok = 1'b1;
    end
  end

  assign pin_lvl  = sync2_q[ch_q];
  assign wake_lim = (mode_q == MODE_DHT11) ? Wake11Lim : Wake22Lim;
  assign tmo      = tick && (cnt_q >= TmoLim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      ch_q      <= '0;
      mode_q    <= MODE_DHT11;
      err_q     <= ErrOk;
      drv_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= ErrOk;
      ch_out    <= '0;
      frame     <= '0;
    end else begin
      done <= 1'b0;
      // Free-running saturating count; every transition below overrides it with 0
      if (tick && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);

      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // The done cycle still reads as idle; defer a coincident start by one clock
          if (start && !done) begin
            ch_q      <= ch_sel;
            mode_q    <= mode;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            busy      <= 1'b1;
            err_q     <= ErrOk;
            if (ch_ok) begin
              drv_q   <= 1'b1;
              state_q <= StWake;
            end else begin
              err_q   <= ErrNoResp;
              state_q <= StFin;
            end
          end
        end
        StWake: if (tick && (cnt_q >= wake_lim)) begin
          drv_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= StRel;
        end
        StRel: if (tick && (cnt_q >= RelLim)) begin
          cnt_q   <= '0;
          state_q <= StWaitLow;
        end
        StWaitLow: begin
          if (!pin_lvl) begin
            cnt_q   <= '0;
            state_q <= StRespLow;
          end else if (tick && (cnt_q >= WaitLim)) begin
            err_q   <= ErrNoResp;
            cnt_q   <= '0;
            state_q <= StRecover;
          end
        end
        StRespLow: begin
          if (pin_lvl) begin
            cnt_q   <= '0;
            state_q <= StRespHigh;
          end else if (tmo) begin
            err_q   <= ErrRespLow;
            cnt_q   <= '0;
            state_q <= StRecover;
          end
        end
        StRespHigh: begin
          if (!pin_lvl) begin
            cnt_q   <= '0;
            state_q <= StBitLow;
          end else if (tmo) begin
            err_q   <= ErrRespHigh;
            cnt_q   <= '0;
            state_q <= StRecover;
          end
        end
        StBitLow: begin
          if (pin_lvl) begin
            cnt_q   <= '0;
            state_q <= StBitHigh;
          end else if (tmo) begin
            err_q   <= ErrBitLow;
            cnt_q   <= '0;
            state_q <= StRecover;
          end
        end
        StBitHigh: begin
          if (!pin_lvl) begin
            // Bit value is the length of the high pulse
            sh_q      <= {sh_q[DHT_FRAME_W-2:0], (cnt_q > Bit1Thr)};
            bit_cnt_q <= bit_cnt_q + 6'd1;
            cnt_q     <= '0;
            state_q   <= (bit_cnt_q == LastBit) ? StCheck : StBitLow;
          end else if (tmo) begin
            err_q   <= ErrBitHigh;
            cnt_q   <= '0;
            state_q <= StRecover;
          end
        end
        StCheck: begin
          err_q   <= frame_sum_ok(sh_q) ? ErrOk : ErrChecksum;
          cnt_q   <= '0;
          state_q <= StRecover;
        end
        StRecover: if (tick && (cnt_q >= RecLim)) begin
          cnt_q   <= '0;
          state_q <= StFin;
        end
        StFin: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          err_code <= err_q;
          ch_out   <= ch_q;
          // Checksum failures still expose the raw bits
          if ((err_q == ErrOk) || (err_q == ErrChecksum)) frame <= sh_q;
          cnt_q    <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
